// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC, fetches over a
// valid/ready request + valid response handshake and holds each instruction until retirement.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            inst_ready,
    input  logic [1:0]      npc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            halt,
    output logic            halted,
    output logic            fetch_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t          r_state;
    logic            r_boot;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic            r_req_valid;
    logic            r_inst_valid;
    logic            r_halted;
    logic            r_misaligned;
    logic [XLEN-1:0] w_npc;

    always_comb begin
        w_npc = r_pc + XLEN'(4);
        case (npc_sel)
            2'd1:    w_npc = branch_target;
            2'd2:    w_npc = {jalr_target[XLEN-1:1], 1'b0};
            default: w_npc = r_pc + XLEN'(4);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_boot       <= 1'b0;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                // IDLE spans one full cycle so the first request follows the second edge.
                S_IDLE: begin
                    if (r_boot) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end else begin
                        r_boot <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_state      <= S_VALID;
                        r_inst       <= imem_resp_data;
                        r_inst_valid <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        r_pc         <= w_npc;
                        r_inst_valid <= 1'b0;
                        if (w_npc[1]) begin
                            r_misaligned <= 1'b1;
                        end
                        if (w_npc[1] || halt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid   = r_req_valid;
    assign imem_req_addr    = r_pc;
    assign inst_valid       = r_inst_valid;
    assign inst             = r_inst;
    assign pc               = r_pc;
    assign halted           = r_halted;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized transactions
// checked against a transaction-level PC/halt model.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_ready = 1'b0;
    logic [1:0]  npc_sel = '0;
    logic [63:0] branch_target = '0;
    logic [63:0] jalr_target = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic        fetch_misaligned;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [63:0] exp_pc;
    logic        exp_mis;
    logic        exp_halted;

    ifu_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
        .pc(pc), .inst_ready(inst_ready), .npc_sel(npc_sel),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .halt(halt), .halted(halted), .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs before any edge, then releases.
    task automatic do_reset(input logic stale);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_misaligned", fetch_misaligned, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 0);
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        halt = 1'b0;
        imem_resp_valid = stale;
        imem_resp_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("boot_edge1_req", imem_req_valid, 0);
        chk("boot_edge1_ivalid", inst_valid, 0);
        tick();
        imem_resp_valid = 1'b0;
        chk("boot_edge2_req", imem_req_valid, 1);
        chk("boot_edge2_addr", imem_req_addr, RST_PC);
        chk("boot_stale_ivalid", inst_valid, 0);
        exp_pc = RST_PC;
        exp_mis = 1'b0;
        exp_halted = 1'b0;
    endtask

    task automatic hold_halted(input int n);
        for (int i = 0; i < n; i++) begin
            imem_req_ready = 1'($urandom);
            imem_resp_valid = 1'($urandom);
            imem_resp_data = $urandom;
            inst_ready = 1'($urandom);
            halt = 1'($urandom);
            npc_sel = 2'($urandom);
            tick();
            chk("halt_req_valid", imem_req_valid, 0);
            chk("halt_inst_valid", inst_valid, 0);
            chk("halt_halted", halted, 1);
            chk("halt_pc", pc, exp_pc);
            chk("halt_misaligned", fetch_misaligned, exp_mis);
        end
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        halt = 1'b0;
    endtask

    // One full request/response/retire transaction; DUT must be in REQ on entry.
    task automatic fetch(input int rd, input int sd, input int td, input logic [1:0] sel,
                         input logic [63:0] bt, input logic [63:0] jt, input logic hl,
                         input logic [31:0] d, input logic early);
        logic [63:0] npc;
        logic        mis;
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_req_addr, exp_pc);
        for (int i = 0; i < rd; i++) begin
            imem_req_ready = 1'b0;
            imem_resp_valid = 1'($urandom);
            inst_ready = 1'($urandom);
            halt = 1'($urandom);
            tick();
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        imem_resp_valid = early;
        imem_resp_data = ~d;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        chk("accept_req_valid", imem_req_valid, 0);
        chk("accept_inst_valid", inst_valid, 0);
        for (int i = 0; i < sd; i++) begin
            inst_ready = 1'($urandom);
            halt = 1'($urandom);
            imem_req_ready = 1'($urandom);
            tick();
            chk("wait_inst_valid", inst_valid, 0);
            chk("wait_req_valid", imem_req_valid, 0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = d;
        inst_ready = 1'($urandom);
        halt = 1'($urandom);
        tick();
        imem_resp_valid = 1'b0;
        chk("resp_inst_valid", inst_valid, 1);
        chk("resp_inst", inst, d);
        chk("resp_pc", pc, exp_pc);
        for (int i = 0; i < td; i++) begin
            imem_resp_valid = 1'($urandom);
            imem_resp_data = $urandom;
            imem_req_ready = 1'($urandom);
            inst_ready = 1'b0;
            halt = 1'($urandom);
            tick();
            chk("valid_hold", inst_valid, 1);
            chk("valid_inst", inst, d);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        npc_sel = sel;
        branch_target = bt;
        jalr_target = jt;
        halt = hl;
        tick();
        inst_ready = 1'b0;
        halt = 1'b0;
        case (sel)
            2'd1:    npc = bt;
            2'd2:    npc = jt - (jt % 2);
            default: npc = exp_pc + 64'd4;
        endcase
        mis = (npc % 4) >= 2;
        exp_pc = npc;
        if (mis) exp_mis = 1'b1;
        exp_halted = mis || hl;
        chk("retire_pc", pc, exp_pc);
        chk("retire_inst_valid", inst_valid, 0);
        chk("retire_halted", halted, exp_halted);
        chk("retire_misaligned", fetch_misaligned, exp_mis);
        chk("retire_req_valid", imem_req_valid, !exp_halted);
    endtask

    initial begin
        logic [63:0] bt;
        logic [63:0] jt;
        exp_pc = RST_PC;
        exp_mis = 1'b0;
        exp_halted = 1'b0;

        do_reset(1'b0);
        fetch(0, 0, 0, 2'd0, '0, '0, 1'b0, 32'h0000_0013, 1'b0);
        fetch(4, 3, 1, 2'd0, '0, '0, 1'b0, 32'h0000_0013, 1'b1);
        fetch(1, 0, 0, 2'd3, 64'h1234, 64'h5678, 1'b0, 32'h0010_0093, 1'b0);
        fetch(0, 1, 0, 2'd0, '0, '0, 1'b0, 32'h0020_0113, 1'b0);
        chk("pc_at_branch", pc, 64'h8000_0010);
        fetch(0, 0, 0, 2'd1, 64'h8000_0100, '0, 1'b0, 32'h0F00_006F, 1'b0);
        fetch(0, 0, 2, 2'd2, '0, 64'h8000_0201, 1'b0, 32'h0000_8067, 1'b0);
        fetch(0, 0, 0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0, 32'h0000_006F, 1'b0);
        fetch(0, 0, 0, 2'd0, '0, '0, 1'b0, 32'h0000_0013, 1'b0);
        chk("wrap_pc", pc, 64'h0);
        fetch(0, 0, 0, 2'd1, 64'h8000_0102, '0, 1'b0, 32'h0000_0063, 1'b0);
        hold_halted(20);

        do_reset(1'b0);
        fetch(0, 0, 0, 2'd0, '0, '0, 1'b1, 32'h0010_0073, 1'b0);
        chk("ebreak_pc", pc, RST_PC + 64'd4);
        hold_halted(20);

        do_reset(1'b0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("midwait_req_valid", imem_req_valid, 0);
        do_reset(1'b1);

        for (int k = 0; k < 80; k++) begin
            if (exp_halted) begin
                hold_halted(2);
                do_reset(1'($urandom));
            end
            bt = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(7) == 0) bt = bt | 64'h2;
            jt = {$urandom, $urandom} & ~64'h2;
            if ($urandom_range(7) == 0) jt = jt | 64'h2;
            fetch(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(2)),
                  2'($urandom), bt, jt, $urandom_range(9) == 0, $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
